sonar_scheduler: RTL and testbench
==================================

// Module: sonar_scheduler
// PURPOSE
//   Round-robin sequencer for the robot's ultrasonic rangefinders. Fires one sonar at a time
//   (avoids acoustic crosstalk), times its echo pulse and latches a 32-bit width per sonar.
//   Result buses feed the sonar_N PIO inputs of the HPS system, so software only reads registers.
// PARAMETERS
//   NUM_SONAR       2          number of sonars, served in index order 0..NUM_SONAR-1
//   TRIG_CYCLES     500        trigger pulse length in clk cycles (10 us at 50 MHz)
//   TIMEOUT_CYCLES  1_500_000  max cycles from trigger end to echo fall (30 ms); must be < 2^32-1
//   HOLDOFF_CYCLES  500_000    quiet gap after each measurement before the next trigger (10 ms)
// PORTS
//   clk            in   1             system clock (50 MHz)
//   reset          in   1             synchronous, active-high reset
//   enable         in   1             1 = keep cycling through the sonars, 0 = stop at the next idle point
//   echo           in   NUM_SONAR     raw echo pins, asynchronous to clk
//   trig           out  NUM_SONAR     trigger pins; at most one bit high at any time
//   result         out  32*NUM_SONAR  slice i = last result of sonar i (echo width in cycles)
//   result_valid   out  1             one-cycle pulse when any result slice updates
//   result_idx     out  8             index of the slice that just updated; valid with result_valid
//   busy           out  1             high whenever state != IDLE
// BEHAVIOUR
//   Reset values: trig=0, result=0 (all slices), result_valid=0, result_idx=0, busy=0.
//     State goes to IDLE, cur=0, all counters=0.
//   Echo inputs pass through a 2-flop synchronizer, then a rise/fall detector. This adds 2 cycles
//     of latency, equal on both edges, so the measured width is unaffected.
//   FSM states and transitions:
//     IDLE:      if enable, go to TRIG; cnt=0.
//     TRIG:      trig[cur]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE; cnt=0.
//     WAIT_RISE: on a synced echo rise, go to MEASURE with width=1.
//                A level already high on entry is not a rise.
//     MEASURE:   width increments every cycle echo_s is high. On fall, latch width into
//                result[cur] and pulse result_valid, then go to HOLDOFF.
//     Timeout:   cnt counts every cycle in WAIT_RISE and MEASURE. When cnt reaches TIMEOUT_CYCLES,
//                latch 32'hFFFF_FFFF into result[cur], pulse result_valid, go to HOLDOFF.
//     HOLDOFF:   wait HOLDOFF_CYCLES cycles. Then cur=(cur==NUM_SONAR-1)?0:cur+1 (wrap-around).
//                Go to TRIG if enable, else to IDLE.
//   Simultaneous fall and timeout in the same cycle: the fall wins and the real width is latched.
//   width saturates at 32'hFFFF_FFFE, so it is never confused with the timeout code.
//   Echo on a non-selected sonar is ignored.
//   enable is sampled only in IDLE and at the end of HOLDOFF.
//     Deasserting it mid-measurement lets that measurement and its holdoff complete.
//   Reset mid-operation: trig drops on the next edge; every result slice clears to 0.
//   Results update only at measurement end; slices of other sonars hold their values.
//   Result latency: result slice and result_valid change on the clk edge after the synced fall
//     is detected.
// STRUCTURE
//   sonar_pkg: state enum {IDLE,TRIG,WAIT_RISE,MEASURE,HOLDOFF}, SONAR_TIMEOUT_CODE=32'hFFFF_FFFF,
//     SONAR_WIDTH_MAX=32'hFFFF_FFFE.
//   One sub-module, echo_sync: 2-flop synchronizer plus edge detector, instantiated per sonar
//     with a generate loop. Outputs echo_s, rise, fall.
//   Top level holds the FSM, the cur index, the cnt/width counters and the result registers.
// TESTING  (bench params: TRIG_CYCLES=4, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=10, NUM_SONAR=2)
//   1. Reset, enable=1, sonar0 echo high 20 cycles after trig ends for 37 cycles
//      -> trig[0] high exactly 4 cycles; result[31:0]=37; one result_valid pulse with idx=0.
//   2. Continuous run, sonar1 echo 50 cycles -> order is 0,1,0; result[63:32]=50;
//      trig bits never overlap; 10-cycle gap between the end of one measurement and the next trig.
//   3. No echo on sonar0 -> 100 cycles after trig ends, result[31:0]=32'hFFFF_FFFF with a
//      valid pulse; sonar1 is then served normally.
//   4. Echo stuck high before WAIT_RISE -> no rise is seen, so the timeout code is latched.
//      Echo rising 99 cycles after trig and still high -> timeout code.
//   5. enable dropped during MEASURE -> measurement completes and is reported; after holdoff the
//      FSM goes to IDLE with busy=0 and no further trig pulses.
//   6. reset asserted during MEASURE -> next cycle: trig=0, result=0, busy=0; with enable=1 after
//      release, the first trig goes to sonar 0.

Source files
------------

// File: rtl/sonar_scheduler_pkg.sv
// Shared types and constants for the sonar scheduler.
//   sonar_state_e      : sequencer FSM states
//   SONAR_TIMEOUT_CODE : result value latched when no complete echo arrives in time
//   SONAR_WIDTH_MAX    : saturation ceiling for a real width, one below the timeout code
//   sat_inc()          : saturating width increment
package sonar_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StHoldoff
    } sonar_state_e;

    localparam logic [31:0] SONAR_TIMEOUT_CODE = 32'hFFFF_FFFF;
    localparam logic [31:0] SONAR_WIDTH_MAX    = 32'hFFFF_FFFE;

    // Never reaches the timeout code, so software can always tell the two apart.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v >= SONAR_WIDTH_MAX) ? SONAR_WIDTH_MAX : v + 32'd1;
    endfunction

endpackage

// File: rtl/sonar_scheduler_if.sv
// Bundle of the sonar scheduler's control, pin and result signals.
//   enable       : keep cycling through the sonars
//   echo         : raw echo pins (asynchronous)
//   trig         : trigger pins, at most one high
//   result       : 32-bit slice per sonar, last measured width or timeout code
//   result_valid : one-cycle pulse when a slice updates
//   result_idx   : index of the slice that just updated
//   busy         : sequencer not idle
// slave = the scheduler, master = whoever drives enable/echo and reads results.
interface sonar_scheduler_if #(
    parameter int unsigned NUM_SONAR = 2
);
    logic                    enable;
    logic [NUM_SONAR-1:0]    echo;
    logic [NUM_SONAR-1:0]    trig;
    logic [32*NUM_SONAR-1:0] result;
    logic                    result_valid;
    logic [7:0]              result_idx;
    logic                    busy;

    modport master (
        output enable, echo,
        input  trig, result, result_valid, result_idx, busy
    );

    modport slave (
        input  enable, echo,
        output trig, result, result_valid, result_idx, busy
    );
endinterface

// File: rtl/sonar_scheduler_echo_sync.sv
// Echo synchronizer: two-flop synchronizer followed by a rise/fall detector.
//   clk, reset : system clock, synchronous active-high reset
//   echo_i     : raw asynchronous echo pin
//   echo_s_o   : synchronized echo level
//   rise_o     : one-cycle pulse on a synchronized 0->1 edge
//   fall_o     : one-cycle pulse on a synchronized 1->0 edge
// Both edges see the same two-cycle latency, so measured widths are unaffected.
module sonar_scheduler_echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo_i,
    output logic echo_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign echo_s_o = sync_q;
    assign rise_o   = sync_q & ~prev_q;
    assign fall_o   = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic rangefinder sequencer. Fires one sonar at a time, times its echo
// pulse in clk cycles and latches a 32-bit width per sonar for the HPS PIO inputs.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : sonar_scheduler_if slave (enable, echo in; trig, result, result_valid,
//                result_idx, busy out)
module sonar_scheduler
    import sonar_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SONAR      = 2,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned HOLDOFF_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    sonar_scheduler_if.slave bus
);

    localparam int unsigned CurW = (NUM_SONAR > 1) ? $clog2(NUM_SONAR) : 1;
    localparam logic [CurW-1:0] LastIdx     = CurW'(NUM_SONAR - 1);
    localparam logic [31:0]     TrigLast    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0]     TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     HoldLast    = 32'(HOLDOFF_CYCLES - 1);

    logic [NUM_SONAR-1:0] echo_s;
    logic [NUM_SONAR-1:0] echo_rise;
    logic [NUM_SONAR-1:0] echo_fall;

    for (genvar i = 0; i < NUM_SONAR; i++) begin : g_sync
        sonar_scheduler_echo_sync u_sync (
            .clk      (clk),
            .reset    (reset),
            .echo_i   (bus.echo[i]),
            .echo_s_o (echo_s[i]),
            .rise_o   (echo_rise[i]),
            .fall_o   (echo_fall[i])
        );
    end

    sonar_state_e         state_q, state_d;
    logic [CurW-1:0]      cur_q, cur_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          width_q, width_d;
    logic [31:0]          result_q [NUM_SONAR];
    logic [31:0]          result_d [NUM_SONAR];
    logic                 valid_q, valid_d;
    logic [7:0]           idx_q, idx_d;
    logic [NUM_SONAR-1:0] trig_q, trig_d;

    logic        sel_s;
    logic        sel_rise;
    logic        sel_fall;
    logic        finish;
    logic [31:0] finish_val;

    // Only the selected sonar's echo is ever looked at.
    assign sel_s    = echo_s[cur_q];
    assign sel_rise = echo_rise[cur_q];
    assign sel_fall = echo_fall[cur_q];

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        width_d    = width_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        idx_d      = idx_q;
        trig_d     = '0;
        finish     = 1'b0;
        finish_val = SONAR_TIMEOUT_CODE;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StTrig;
                    cnt_d   = '0;
                end
            end
            StTrig: begin
                if (cnt_q == TrigLast) begin
                    state_d = StWaitRise;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitRise: begin
                cnt_d = cnt_q + 32'd1;
                // A level already high on entry produces no rise pulse, so it times out.
                if (cnt_q >= TimeoutLast) begin
                    finish = 1'b1;
                end else if (sel_rise) begin
                    state_d = StMeasure;
                    width_d = 32'd1;
                end
            end
            StMeasure: begin
                cnt_d = cnt_q + 32'd1;
                // Fall is checked first so a fall coinciding with timeout keeps the real width.
                if (sel_fall) begin
                    finish     = 1'b1;
                    finish_val = width_q;
                end else if (cnt_q >= TimeoutLast) begin
                    finish = 1'b1;
                end else if (sel_s) begin
                    width_d = sat_inc(width_q);
                end
            end
            StHoldoff: begin
                if (cnt_q == HoldLast) begin
                    cur_d   = (cur_q == LastIdx) ? '0 : cur_q + 1'b1;
                    state_d = bus.enable ? StTrig : StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (finish) begin
            result_d[cur_q] = finish_val;
            valid_d         = 1'b1;
            idx_d           = 8'(cur_q);
            state_d         = StHoldoff;
            cnt_d           = '0;
        end

        // Registered trigger: high exactly while the next state is StTrig.
        if (state_d == StTrig) begin
            trig_d[cur_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cur_q   <= '0;
            cnt_q   <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            trig_q  <= '0;
            for (int i = 0; i < NUM_SONAR; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            trig_q   <= trig_d;
            result_q <= result_d;
        end
    end

    for (genvar i = 0; i < NUM_SONAR; i++) begin : g_result
        assign bus.result[32*i +: 32] = result_q[i];
    end

    assign bus.trig         = trig_q;
    assign bus.result_valid = valid_q;
    assign bus.result_idx   = idx_q;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with short trigger/timeout/holdoff counts.
// Each serve() call waits for the expected trigger, plays an echo pattern relative to the
// trigger's falling edge and checks the latched result, its latency and the pulse shape.
module tb_sonar_scheduler;

    localparam int TRIG    = 4;
    localparam int TIMEOUT = 100;
    localparam int HOLD    = 10;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   last_vabs = -1;
    int   overlap = 0;
    bit   mon_en = 1'b0;
    logic [31:0] exp_res [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sonar_scheduler_if #(.NUM_SONAR(2)) sb ();

    sonar_scheduler #(
        .NUM_SONAR      (2),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb)
    );

    always @(negedge clk) begin
        if (mon_en && !$onehot0(sb.trig)) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one sonar: echo raw-high for 'width' cycles starting 'delay' cycles after trig falls.
    task automatic serve(input string tag, input int s, input int delay, input int width,
                         input bit pre_high, input bit noise, input int drop_at);
        int          t;
        int          hi;
        int          vcyc;
        int          npulse;
        int          exp_lat;
        logic [31:0] exp_v;
        logic [31:0] got_slice;
        logic [7:0]  got_idx;
        logic [1:0]  want_trig;

        want_trig = 2'b01 << s;
        if (pre_high) sb.echo[s] = 1'b1;
        t = 0;
        while (sb.trig == 2'b00 && t < 200) begin
            step();
            t++;
        end
        chk({tag, "_trig_sel"}, 64'(sb.trig), 64'(want_trig));
        chk({tag, "_busy"}, 64'(sb.busy), 64'd1);
        if (last_vabs >= 0) chk({tag, "_gap"}, 64'(cyc - last_vabs), 64'(HOLD));
        hi = 0;
        while (sb.trig[s] && hi < 50) begin
            hi++;
            step();
        end
        chk({tag, "_trig_len"}, 64'(hi), 64'(TRIG));

        vcyc      = -1;
        npulse    = 0;
        got_slice = '0;
        got_idx   = '0;
        for (int c = 0; c < 260; c++) begin
            sb.echo[s] = pre_high || (width > 0 && c >= delay && c < delay + width);
            if (noise) sb.echo[1-s] = (c >= 3 && c < 40);
            if (c == drop_at) sb.enable = 1'b0;
            step();
            if (sb.result_valid) begin
                npulse++;
                if (vcyc < 0) begin
                    vcyc      = c + 1;
                    last_vabs = cyc;
                    got_slice = sb.result[32*s +: 32];
                    got_idx   = sb.result_idx;
                end
            end
            if (vcyc >= 0 && c + 1 > vcyc) break;
        end
        sb.echo = 2'b00;

        // Synced rise is seen 2 cycles after the raw rise, fall 2 after raw fall, result 1 later.
        if (!pre_high && width > 0 && delay + 2 <= TIMEOUT - 2 && delay + width + 3 <= TIMEOUT)
        begin
            exp_v   = 32'(width);
            exp_lat = delay + width + 3;
        end else begin
            exp_v   = 32'hFFFF_FFFF;
            exp_lat = TIMEOUT;
        end
        exp_res[s] = exp_v;

        chk({tag, "_latency"}, 64'(vcyc), 64'(exp_lat));
        chk({tag, "_pulses"}, 64'(npulse), 64'd1);
        chk({tag, "_idx"}, 64'(got_idx), 64'(s));
        chk({tag, "_slice"}, 64'(got_slice), 64'(exp_v));
        chk({tag, "_all"}, 64'(sb.result), {exp_res[1], exp_res[0]});
    endtask

    initial begin
        int t;
        int hi;
        int trig_seen;

        reset     = 1'b1;
        sb.enable = 1'b0;
        sb.echo   = 2'b00;
        exp_res[0] = '0;
        exp_res[1] = '0;
        repeat (3) step();
        chk("rst_trig", 64'(sb.trig), 64'd0);
        chk("rst_result", 64'(sb.result), 64'd0);
        chk("rst_valid", 64'(sb.result_valid), 64'd0);
        chk("rst_idx", 64'(sb.result_idx), 64'd0);
        chk("rst_busy", 64'(sb.busy), 64'd0);

        reset     = 1'b0;
        mon_en    = 1'b1;
        sb.enable = 1'b1;

        serve("t1_s0", 0, 20, 37, 1'b0, 1'b0, -1);
        serve("t2_s1", 1, 10, 50, 1'b0, 1'b1, -1);
        serve("t2_s0", 0, 5, 12, 1'b0, 1'b0, -1);
        serve("s1_short", 1, 30, 5, 1'b0, 1'b0, -1);
        serve("t3_s0_noecho", 0, 0, 0, 1'b0, 1'b0, -1);
        serve("t3_s1", 1, 0, 8, 1'b0, 1'b0, -1);
        serve("s0_fall_wins", 0, 20, 77, 1'b0, 1'b0, -1);
        serve("s1_late_fall", 1, 20, 78, 1'b0, 1'b0, -1);
        serve("t4_s0_stuck", 0, 0, 0, 1'b1, 1'b0, -1);
        serve("t4_s1_late_rise", 1, 99, 20, 1'b0, 1'b0, -1);
        serve("t5_s0_drop", 0, 10, 30, 1'b0, 1'b0, 20);

        // Holdoff still running right after the result, then idle with no new triggers.
        chk("t5_busy_holdoff", 64'(sb.busy), 64'd1);
        repeat (11) step();
        chk("t5_busy_idle", 64'(sb.busy), 64'd0);
        trig_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (sb.trig != 2'b00) trig_seen++;
            step();
        end
        chk("t5_no_trig", 64'(trig_seen), 64'd0);

        // Reset in the middle of a sonar 1 measurement.
        sb.enable = 1'b1;
        t = 0;
        while (sb.trig == 2'b00 && t < 50) begin
            step();
            t++;
        end
        chk("t6_pre_trig_sel", 64'(sb.trig), 64'b10);
        hi = 0;
        while (sb.trig[1] && hi < 50) begin
            hi++;
            step();
        end
        for (int c = 0; c < 20; c++) begin
            sb.echo[1] = (c >= 5);
            step();
        end
        chk("t6_pre_busy", 64'(sb.busy), 64'd1);
        reset   = 1'b1;
        sb.echo = 2'b00;
        step();
        chk("t6_trig", 64'(sb.trig), 64'd0);
        chk("t6_result", 64'(sb.result), 64'd0);
        chk("t6_busy", 64'(sb.busy), 64'd0);
        chk("t6_valid", 64'(sb.result_valid), 64'd0);
        chk("t6_idx", 64'(sb.result_idx), 64'd0);
        reset      = 1'b0;
        exp_res[0] = '0;
        exp_res[1] = '0;
        last_vabs  = -1;
        serve("t6_s0_after", 0, 10, 25, 1'b0, 1'b0, -1);

        chk("trig_overlap", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
